// File: rtl/reg_file_pkg.sv
// reg_file_pkg: default sizes and word/select types shared by the register file slice
package reg_file_pkg;
  localparam int WORD_W = 32;
  localparam int NUM_WORDS = 32;
  localparam int SEL_W = $clog2(NUM_WORDS);
  typedef logic [WORD_W-1:0] word_t;
  typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/reg_file_mp_if.sv
// reg_file_mp_if: issue/writeback bus of the multi-port register file
// master drives writes (wen/wsel/wdata), reads (rsel) and reservations (rsv_en/rsv_sel);
// slave returns rdata/rbusy per read port and the registered wr_conflict pulse
interface reg_file_mp_if
  import reg_file_pkg::*;
#(
  parameter int WORD_W = reg_file_pkg::WORD_W,
  parameter int SEL_W = reg_file_pkg::SEL_W,
  parameter int NUM_RPORTS = 2,
  parameter int NUM_WPORTS = 2
);
  logic [NUM_WPORTS-1:0] wen;
  logic [NUM_WPORTS-1:0][SEL_W-1:0] wsel;
  logic [NUM_WPORTS-1:0][WORD_W-1:0] wdata;
  logic [NUM_RPORTS-1:0][SEL_W-1:0] rsel;
  logic [NUM_RPORTS-1:0][WORD_W-1:0] rdata;
  logic [NUM_RPORTS-1:0] rbusy;
  logic rsv_en;
  logic [SEL_W-1:0] rsv_sel;
  logic wr_conflict;
  modport master (output wen, wsel, wdata, rsel, rsv_en, rsv_sel, input rdata, rbusy, wr_conflict);
  modport slave (input wen, wsel, wdata, rsel, rsv_en, rsv_sel, output rdata, rbusy, wr_conflict);
endinterface

// File: rtl/reg_file_mp_wr_resolve.sv
// rf_wr_resolve: per-register write hit, winning data and collision flag from all write ports
// in: wen/wsel/wdata per write port; out: hit/hdata/coll per register
module rf_wr_resolve
  import reg_file_pkg::*;
#(
  parameter int WORD_W = reg_file_pkg::WORD_W,
  parameter int NUM_WORDS = reg_file_pkg::NUM_WORDS,
  parameter int SEL_W = reg_file_pkg::SEL_W,
  parameter int NUM_WPORTS = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic [NUM_WPORTS-1:0] wen,
  input  logic [NUM_WPORTS-1:0][SEL_W-1:0] wsel,
  input  logic [NUM_WPORTS-1:0][WORD_W-1:0] wdata,
  output logic [NUM_WORDS-1:0] hit,
  output logic [NUM_WORDS-1:0][WORD_W-1:0] hdata,
  output logic [NUM_WORDS-1:0] coll
);
  // later ports overwrite earlier ones, so the highest port index wins;
  // out-of-range selects never match a register and are dropped here
  always_comb begin
    hit = '0;
    hdata = '0;
    coll = '0;
    for (int r = 0; r < NUM_WORDS; r++)
      for (int p = 0; p < NUM_WPORTS; p++)
        if (wen[p] && wsel[p] == SEL_W'(r) && !(ZERO_REG && r == 0)) begin
          coll[r] = coll[r] | hit[r];
          hit[r] = 1'b1;
          hdata[r] = wdata[p];
        end
  end
endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: N-read/M-write register file with busy scoreboard, bypass and zero register
// clk, reset (async, active-high); bus: reg_file_mp_if.slave carrying write ports,
// combinational read ports (rdata/rbusy), destination reservation and wr_conflict
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int WORD_W = reg_file_pkg::WORD_W,
  parameter int NUM_WORDS = reg_file_pkg::NUM_WORDS,
  parameter int SEL_W = reg_file_pkg::SEL_W,
  parameter int NUM_RPORTS = 2,
  parameter int NUM_WPORTS = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS = 1'b1,
  parameter logic [WORD_W-1:0] RESET_VAL = '0
) (
  input logic clk,
  input logic reset,
  reg_file_mp_if.slave bus
);
  logic [NUM_WORDS-1:0][WORD_W-1:0] mem;
  logic [NUM_WORDS-1:0] busy;
  logic [NUM_WORDS-1:0] hit;
  logic [NUM_WORDS-1:0][WORD_W-1:0] hdata;
  logic [NUM_WORDS-1:0] coll;
  logic [NUM_WORDS-1:0] rsv_hit;
  logic [NUM_RPORTS-1:0][WORD_W-1:0] rdata;
  logic [NUM_RPORTS-1:0] rbusy;
  logic conflict;
  rf_wr_resolve #(
    .WORD_W(WORD_W),
    .NUM_WORDS(NUM_WORDS),
    .SEL_W(SEL_W),
    .NUM_WPORTS(NUM_WPORTS),
    .ZERO_REG(ZERO_REG)
  ) u_resolve (
    .wen(bus.wen),
    .wsel(bus.wsel),
    .wdata(bus.wdata),
    .hit(hit),
    .hdata(hdata),
    .coll(coll)
  );
  always_comb begin
    rsv_hit = '0;
    for (int r = 0; r < NUM_WORDS; r++)
      rsv_hit[r] = bus.rsv_en && bus.rsv_sel == SEL_W'(r) && !(ZERO_REG && r == 0);
  end
  // a same-cycle reservation belongs to a newer instruction, so it beats the write's clear
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int r = 0; r < NUM_WORDS; r++)
        mem[r] <= (ZERO_REG && r == 0) ? '0 : RESET_VAL;
      busy <= '0;
      conflict <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_WORDS; r++) begin
        mem[r] <= hit[r] ? hdata[r] : mem[r];
        busy[r] <= rsv_hit[r] ? 1'b1 : hit[r] ? 1'b0 : busy[r];
      end
      conflict <= |coll;
    end
  // unmatched (out-of-range) selects fall through to zero; register 0 is never
  // written or reserved under ZERO_REG, so it reads 0 and not busy without a special case
  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int j = 0; j < NUM_RPORTS; j++)
      for (int r = 0; r < NUM_WORDS; r++)
        if (bus.rsel[j] == SEL_W'(r)) begin
          rdata[j] = (BYPASS && hit[r]) ? hdata[r] : mem[r];
          rbusy[j] = !(BYPASS && hit[r]) && busy[r];
        end
  end
  assign bus.rdata = rdata;
  assign bus.rbusy = rbusy;
  assign bus.wr_conflict = conflict;
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: scoreboard bench for reg_file_mp with bypass and non-bypass instances
module tb_reg_file_mp;
  import reg_file_pkg::*;
  localparam word_t RV = 32'hDEAD_BEEF;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] wen;
  logic [1:0][4:0] wsel;
  logic [1:0][31:0] wdata;
  logic [1:0][4:0] rsel;
  logic rsv_en;
  logic [4:0] rsv_sel;
  always #5 clk = ~clk;
  reg_file_mp_if ifa ();
  reg_file_mp_if ifb ();
  assign ifa.wen = wen;
  assign ifa.wsel = wsel;
  assign ifa.wdata = wdata;
  assign ifa.rsel = rsel;
  assign ifa.rsv_en = rsv_en;
  assign ifa.rsv_sel = rsv_sel;
  assign ifb.wen = wen;
  assign ifb.wsel = wsel;
  assign ifb.wdata = wdata;
  assign ifb.rsel = rsel;
  assign ifb.rsv_en = rsv_en;
  assign ifb.rsv_sel = rsv_sel;
  reg_file_mp #(.RESET_VAL(RV)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
  reg_file_mp #(.RESET_VAL(RV), .BYPASS(1'b0)) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));
  // kind: 0 = rdata (bypass dut), 1 = rbusy (bypass dut), 2 = wr_conflict, 3 = rdata (no-bypass dut)
  typedef struct {
    string name;
    int kind;
    int port;
    word_t val;
  } exp_t;
  exp_t q[$];
  int total = 0;
  int bad = 0;
  task automatic push(input string n, input int k, input int p, input word_t v);
    exp_t e;
    e.name = n;
    e.kind = k;
    e.port = p;
    e.val = v;
    q.push_back(e);
  endtask
  task automatic rd(input string n, input int p, input word_t d, input logic b);
    push({n, "_data"}, 0, p, d);
    push({n, "_busy"}, 1, p, {31'b0, b});
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    wen = '0;
    rsv_en = 1'b0;
  endtask
  always @(negedge clk)
    while (q.size() > 0) begin
      exp_t e;
      word_t act;
      e = q.pop_front();
      case (e.kind)
        0: act = ifa.rdata[e.port];
        1: act = {31'b0, ifa.rbusy[e.port]};
        2: act = {31'b0, ifa.wr_conflict};
        default: act = ifb.rdata[e.port];
      endcase
      total++;
      if (act !== e.val) begin
        bad++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.val);
      end
    end
  initial begin
    wen = '0;
    wsel = '0;
    wdata = '0;
    rsel = '0;
    rsv_en = 1'b0;
    rsv_sel = '0;
    #2;
    rsel[0] = 5'd0;
    rsel[1] = 5'd1;
    rd("rst_r0", 0, 32'h0, 1'b0);
    rd("rst_r1", 1, RV, 1'b0);
    push("rst_conflict", 2, 0, 32'h0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    tick();
    wen = 2'b11;
    wsel[0] = 5'd5;
    wsel[1] = 5'd9;
    wdata[0] = 32'h11;
    wdata[1] = 32'h22;
    rsel[0] = 5'd5;
    rsel[1] = 5'd9;
    rd("dual_byp0", 0, 32'h11, 1'b0);
    push("dual_byp1", 0, 1, 32'h22);
    push("dual_nobyp0", 3, 0, RV);
    tick();
    idle();
    rsv_en = 1'b1;
    rsv_sel = 5'd7;
    push("dual_rd0", 0, 0, 32'h11);
    push("dual_rd1", 0, 1, 32'h22);
    push("dual_nobyp_rd0", 3, 0, 32'h11);
    push("dual_conflict", 2, 0, 32'h0);
    tick();
    idle();
    wen = 2'b01;
    wsel[0] = 5'd7;
    wdata[0] = 32'hA5A5;
    rsel[0] = 5'd7;
    rsel[1] = 5'd5;
    rd("byp_r7", 0, 32'hA5A5, 1'b0);
    push("byp_off_r7", 3, 0, RV);
    push("byp_r5", 0, 1, 32'h11);
    tick();
    idle();
    rsel[1] = 5'd7;
    rd("byp_after_r7", 0, 32'hA5A5, 1'b0);
    push("byp_off_after_r7", 3, 0, 32'hA5A5);
    tick();
    wen = 2'b11;
    wsel[0] = 5'd3;
    wsel[1] = 5'd3;
    wdata[0] = 32'h1;
    wdata[1] = 32'h2;
    rsel[0] = 5'd3;
    rsel[1] = 5'd5;
    rd("coll_byp_r3", 0, 32'h2, 1'b0);
    push("coll_nobyp_r3", 3, 0, RV);
    push("coll_same_cycle", 2, 0, 32'h0);
    tick();
    idle();
    push("coll_r3", 0, 0, 32'h2);
    push("coll_nobyp_r3_after", 3, 0, 32'h2);
    push("coll_pulse", 2, 0, 32'h1);
    tick();
    rsv_en = 1'b1;
    rsv_sel = 5'd12;
    rsel[0] = 5'd12;
    push("coll_pulse_end", 2, 0, 32'h0);
    rd("rsv_pre", 0, RV, 1'b0);
    tick();
    idle();
    rd("rsv_busy", 0, RV, 1'b1);
    tick();
    wen = 2'b01;
    wsel[0] = 5'd12;
    wdata[0] = 32'h1234;
    rd("rsv_wr_byp", 0, 32'h1234, 1'b0);
    tick();
    idle();
    rd("rsv_cleared", 0, 32'h1234, 1'b0);
    tick();
    rsv_en = 1'b1;
    rsv_sel = 5'd12;
    wen = 2'b10;
    wsel[1] = 5'd12;
    wdata[1] = 32'h5678;
    rd("rsv_and_wr_byp", 0, 32'h5678, 1'b0);
    tick();
    idle();
    rd("rsv_wins", 0, 32'h5678, 1'b1);
    push("rsv_wins_nobyp", 3, 0, 32'h5678);
    tick();
    wen = 2'b11;
    wsel[0] = 5'd0;
    wsel[1] = 5'd0;
    wdata[0] = 32'hFFFF;
    wdata[1] = 32'hFFFF;
    rsv_en = 1'b1;
    rsv_sel = 5'd0;
    rsel[0] = 5'd0;
    rd("zero_byp", 0, 32'h0, 1'b0);
    push("zero_nobyp", 3, 0, 32'h0);
    tick();
    idle();
    rd("zero_after", 0, 32'h0, 1'b0);
    push("zero_no_conflict", 2, 0, 32'h0);
    tick();
    wen = 2'b11;
    wsel[0] = 5'd4;
    wsel[1] = 5'd4;
    wdata[0] = 32'h7;
    wdata[1] = 32'h8;
    rsv_en = 1'b1;
    rsv_sel = 5'd20;
    rsel[0] = 5'd4;
    push("pre_rst_r4", 0, 0, 32'h8);
    tick();
    idle();
    #1;
    reset = 1'b1;
    for (int k = 0; k < 16; k++) begin
      rsel[0] = 5'(2 * k);
      rsel[1] = 5'(2 * k + 1);
      rd($sformatf("midrst_r%0d", 2 * k), 0, k == 0 ? 32'h0 : RV, 1'b0);
      rd($sformatf("midrst_r%0d", 2 * k + 1), 1, RV, 1'b0);
      if (k == 0) push("midrst_conflict", 2, 0, 32'h0);
      @(negedge clk);
      #1;
    end
    reset = 1'b0;
    tick();
    rsel[0] = 5'd4;
    rsel[1] = 5'd20;
    push("post_rst_r4", 0, 0, RV);
    rd("post_rst_r20", 1, RV, 1'b0);
    push("post_rst_conflict", 2, 0, 32'h0);
    tick();
    wen = 2'b01;
    wsel[0] = 5'd20;
    wdata[0] = 32'h99;
    tick();
    idle();
    rd("post_rst_wr20", 1, 32'h99, 1'b0);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
